// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the 4-bit microcore: drives program memory, IR load handshake, 4x4 register file and accumulator.
// Latency: FETCH (1 per mem_rdy wait) + LOAD (>=2) + DECODE (1) + EXEC (1); 5 cycles per instruction minimum.
// Backpressure: mem_rdy low holds FETCH with mem_req high; LOAD waits for ir_ack (bounded by ACK_TIMEOUT when INSTR_SEQ_ACK_TIMEOUT_EN is defined).
//
// Ports:
//   clk, rst (sync, active-high), start       - control
//   pc, mem_req / mem_rdy                     - program memory fetch
//   ir_ena / ir_ack, mnm, wr_addr_mnm,
//   rd_addr_wr_data                           - instruction register load and fields
//   rf_we, rf_wr_addr, rf_wr_data,
//   rf_rd_addr, rf_rd_data                    - register file (combinational read)
//   acc, carry, busy, halted, err             - status
// Optional feature: define INSTR_SEQ_ACK_TIMEOUT_EN to enable the LOAD ack timeout (ERR state).

module instruction_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter logic [3:0]  RESET_PC    = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] pc,
    output logic       mem_req,
    input  logic       mem_rdy,
    output logic       ir_ena,
    input  logic       ir_ack,
    input  logic [1:0] mnm,
    input  logic [1:0] wr_addr_mnm,
    input  logic [3:0] rd_addr_wr_data,
    output logic       rf_we,
    output logic [1:0] rf_wr_addr,
    output logic [3:0] rf_wr_data,
    output logic [1:0] rf_rd_addr,
    input  logic [3:0] rf_rd_data,
    output logic [3:0] acc,
    output logic       carry,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [1:0] MJ_MISC = 2'b00;
    localparam logic [1:0] MJ_LDI  = 2'b01;
    localparam logic [1:0] MJ_MOV  = 2'b10;
    localparam logic [1:0] MJ_ADD  = 2'b11;
    localparam logic [1:0] MI_JMP  = 2'b01;
    localparam logic [1:0] MI_STA  = 2'b10;
    localparam logic [1:0] MI_HALT = 2'b11;

    state_t     state, state_nxt;
    logic       load_first;     // high during the first LOAD cycle, when a stale ack must be ignored
    logic [1:0] op_mnm;
    logic [1:0] op_minor;
    logic [3:0] op_imm;
    logic [3:0] operand;
    logic       is_jmp;
    logic       is_halt;
    logic       timeout;

    assign is_jmp  = (op_mnm == MJ_MISC) && (op_minor == MI_JMP);
    assign is_halt = (op_mnm == MJ_MISC) && (op_minor == MI_HALT);

`ifdef INSTR_SEQ_ACK_TIMEOUT_EN
    localparam logic [3:0] ACK_TO = ACK_TIMEOUT[3:0];

    // Counts LOAD cycles; zero in the first one, so hitting ACK_TO means
    // ACK_TIMEOUT cycles have elapsed past the ignored first cycle.
    logic [3:0] ack_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state == S_LOAD) begin
            ack_cnt <= ack_cnt + 4'd1;
        end else begin
            ack_cnt <= '0;
        end
    end

    assign timeout = (ack_cnt == ACK_TO);
`else
    // Parameter has no effect in this build; LOAD waits for ir_ack forever.
    logic unused_ack_timeout;
    assign unused_ack_timeout = (ACK_TIMEOUT > 15);
    assign timeout            = 1'b0;
`endif

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            load_first <= 1'b1;
            pc         <= RESET_PC;
            acc        <= '0;
            carry      <= 1'b0;
            operand    <= '0;
            op_mnm     <= '0;
            op_minor   <= '0;
            op_imm     <= '0;
        end else begin
            state      <= state_nxt;
            load_first <= (state != S_LOAD);

            if (state == S_DECODE) begin
                operand  <= rf_rd_data;
                op_mnm   <= mnm;
                op_minor <= wr_addr_mnm;
                op_imm   <= rd_addr_wr_data;
            end

            if (state == S_EXEC) begin
                if (op_mnm == MJ_ADD) begin
                    {carry, acc} <= {1'b0, acc} + {1'b0, operand};
                end
                if (is_jmp) begin
                    pc <= op_imm;
                end else if (!is_halt) begin
                    pc <= pc + 4'd1;
                end
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        ir_ena     = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        rf_we      = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        rf_rd_addr = '0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_rdy) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                ir_ena = 1'b1;
                busy   = 1'b1;
                if (ir_ack && !load_first) begin
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_DECODE: begin
                busy       = 1'b1;
                rf_rd_addr = rd_addr_wr_data[1:0];
                state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                state_nxt = is_halt ? S_HALT : S_FETCH;
                case (op_mnm)
                    MJ_LDI: begin
                        rf_we      = 1'b1;
                        rf_wr_addr = op_minor;
                        rf_wr_data = op_imm;
                    end
                    MJ_MOV: begin
                        rf_we      = 1'b1;
                        rf_wr_addr = op_minor;
                        rf_wr_data = operand;
                    end
                    MJ_MISC: begin
                        if (op_minor == MI_STA) begin
                            rf_we      = 1'b1;
                            rf_wr_addr = op_imm[1:0];
                            rf_wr_data = acc;
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
`ifdef INSTR_SEQ_ACK_TIMEOUT_EN
                err = 1'b1;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Reset overrides the write strobe even in the EXEC cycle it lands on.
        if (rst) rf_we = 1'b0;
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: program memory, IR and register file modelled around the DUT,
// results compared per instruction against an ISA-level interpreter, plus directed reset/stall/timeout steps.
// Honour INSTR_SEQ_ACK_TIMEOUT_EN the same way as the RTL build.

module tb_instruction_sequencer;

    localparam int unsigned AT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pc;
    logic       mem_req;
    logic       mem_rdy;
    logic       ir_ena;
    logic       ir_ack = 1'b0;
    logic [1:0] mnm;
    logic [1:0] wr_addr_mnm;
    logic [3:0] rd_addr_wr_data;
    logic       rf_we;
    logic [1:0] rf_wr_addr;
    logic [3:0] rf_wr_data;
    logic [1:0] rf_rd_addr;
    logic [3:0] rf_rd_data;
    logic [3:0] acc;
    logic       carry;
    logic       busy;
    logic       halted;
    logic       err;

    always #5 clk = ~clk;

    instruction_sequencer #(.ACK_TIMEOUT(AT), .RESET_PC(4'h0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pc(pc), .mem_req(mem_req), .mem_rdy(mem_rdy),
        .ir_ena(ir_ena), .ir_ack(ir_ack),
        .mnm(mnm), .wr_addr_mnm(wr_addr_mnm), .rd_addr_wr_data(rd_addr_wr_data),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .acc(acc), .carry(carry), .busy(busy), .halted(halted), .err(err)
    );

    // Environment: program memory, instruction register (acks one cycle after load), register file
    logic [7:0] prog [16];
    logic [7:0] ir = 8'h00;
    logic [3:0] rf [4];
    bit         ack_en = 1'b1;

    assign {mnm, wr_addr_mnm, rd_addr_wr_data} = ir;
    assign rf_rd_data = rf[rf_rd_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
            ir_ack <= 1'b0;
        end else begin
            if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
            ir_ack <= ir_ena & ack_en;
        end
        if (ir_ena) ir <= prog[pc];
    end

    // ISA-level reference state
    logic [3:0] m_pc;
    logic [3:0] m_acc;
    logic       m_carry;
    logic       m_halt;
    logic [3:0] m_rf [4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m_pc    = 4'h0;
        m_acc   = 4'h0;
        m_carry = 1'b0;
        m_halt  = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    endtask

    // Returns at a falling edge with the DUT in FETCH.
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Executes one instruction on the model and on the DUT, then compares.
    task automatic run_instr(input string tag, input bit rand_rdy, output int lat);
        logic [7:0] ins;
        logic [1:0] mj, mi;
        logic [3:0] im;
        logic [4:0] sum;
        bit         exp_we;
        logic [1:0] exp_wa, got_wa;
        logic [3:0] exp_wd, got_wd;
        int         cyc, we_cnt;
        bit         left;

        ins = prog[m_pc];
        mj  = ins[7:6];
        mi  = ins[5:4];
        im  = ins[3:0];
        exp_we = 1'b0; exp_wa = 2'd0; exp_wd = 4'd0;
        case (mj)
            2'b01: begin exp_we = 1'b1; exp_wa = mi; exp_wd = im; end
            2'b10: begin exp_we = 1'b1; exp_wa = mi; exp_wd = m_rf[im[1:0]]; end
            2'b11: begin
                sum     = {1'b0, m_acc} + {1'b0, m_rf[im[1:0]]};
                m_acc   = sum[3:0];
                m_carry = sum[4];
            end
            default: begin
                if (mi == 2'b10) begin exp_we = 1'b1; exp_wa = im[1:0]; exp_wd = m_acc; end
                if (mi == 2'b11) m_halt = 1'b1;
            end
        endcase
        if (exp_we) m_rf[exp_wa] = exp_wd;
        if (mj == 2'b00 && mi == 2'b01) m_pc = im;
        else if (!m_halt) m_pc = m_pc + 4'd1;

        cyc = 0; we_cnt = 0; left = 1'b0; got_wa = 2'd0; got_wd = 4'd0;
        while (cyc < 300) begin
            mem_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc++;
            if (rf_we === 1'b1) begin
                we_cnt++;
                got_wa = rf_wr_addr;
                got_wd = rf_wr_data;
            end
            if (mem_req !== 1'b1) left = 1'b1;
            if (left && (mem_req === 1'b1 || halted === 1'b1)) break;
        end
        mem_rdy = 1'b1;
        lat = cyc;

        check({tag, " completes"}, 32'(left && (mem_req === 1'b1 || halted === 1'b1)), 32'd1);
        check({tag, " pc"},     32'(pc),     32'(m_pc));
        check({tag, " acc"},    32'(acc),    32'(m_acc));
        check({tag, " carry"},  32'(carry),  32'(m_carry));
        check({tag, " halted"}, 32'(halted), 32'(m_halt));
        check({tag, " we count"}, 32'(we_cnt), 32'(exp_we));
        if (exp_we) begin
            check({tag, " wr addr"}, 32'(got_wa), 32'(exp_wa));
            check({tag, " wr data"}, 32'(got_wd), 32'(exp_wd));
        end
        check({tag, " regfile"}, 32'({rf[3], rf[2], rf[1], rf[0]}),
              32'({m_rf[3], m_rf[2], m_rf[1], m_rf[0]}));
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; mem_rdy = 1'b1;
        clear_prog();

        // Reset state
        do_reset();
        check("reset pc",      32'(pc),      32'd0);
        check("reset acc",     32'(acc),     32'd0);
        check("reset carry",   32'(carry),   32'd0);
        check("reset busy",    32'(busy),    32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset ir_ena",  32'(ir_ena),  32'd0);
        check("reset rf_we",   32'(rf_we),   32'd0);
        check("reset halted",  32'(halted),  32'd0);
        check("reset err",     32'(err),     32'd0);
        @(negedge clk);
        check("idle holds", 32'(busy), 32'd0);

        // LDI r1,5 ; HALT
        clear_prog();
        prog[0] = 8'h55; prog[1] = 8'h30;
        do_reset();
        kick();
        check("fetch busy", 32'(busy), 32'd1);
        check("fetch mem_req", 32'(mem_req), 32'd1);
        run_instr("ldi", 1'b0, lat);
        check("ldi latency", 32'(lat), 32'd5);
        check("ldi r1", 32'(rf[1]), 32'd5);
        run_instr("halt", 1'b0, lat);
        check("halt pc", 32'(pc), 32'd1);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("halt ignores start", 32'(halted), 32'd1);
        check("halt busy", 32'(busy), 32'd0);

        // ADD with carry
        clear_prog();
        prog[0] = 8'h49; prog[1] = 8'hC0; prog[2] = 8'hC0; prog[3] = 8'h30;
        do_reset();
        kick();
        run_instr("add ldi", 1'b0, lat);
        run_instr("add 1", 1'b0, lat);
        check("add1 acc", 32'(acc), 32'd9);
        check("add1 carry", 32'(carry), 32'd0);
        run_instr("add 2", 1'b0, lat);
        check("add2 acc", 32'(acc), 32'd2);
        check("add2 carry", 32'(carry), 32'd1);
        run_instr("add halt", 1'b0, lat);

        // STA then MOV reading the just-written register
        clear_prog();
        prog[0] = 8'h49; prog[1] = 8'hC0; prog[2] = 8'h22; prog[3] = 8'hB2; prog[4] = 8'h30;
        do_reset();
        kick();
        for (int i = 0; i < 5; i++) run_instr("sta/mov", 1'b0, lat);
        check("sta r2", 32'(rf[2]), 32'd9);
        check("mov r3", 32'(rf[3]), 32'd9);

        // JMP 15 then NOP at 15 wraps pc to 0
        clear_prog();
        prog[0] = 8'h1F;
        do_reset();
        kick();
        run_instr("jmp", 1'b0, lat);
        check("jmp pc", 32'(pc), 32'd15);
        run_instr("nop wrap", 1'b0, lat);
        check("wrap pc", 32'(pc), 32'd0);

        // Fetch stall, then reset during LOAD
        clear_prog();
        prog[0] = 8'h55;
        do_reset();
        mem_rdy = 1'b0;
        kick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall mem_req", 32'(mem_req), 32'd1);
            check("stall ir_ena",  32'(ir_ena),  32'd0);
            check("stall pc",      32'(pc),      32'd0);
        end
        mem_rdy = 1'b1;
        @(negedge clk);
        check("load ir_ena", 32'(ir_ena), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset ir_ena",  32'(ir_ena),  32'd0);
        check("mid reset busy",    32'(busy),    32'd0);
        check("mid reset mem_req", 32'(mem_req), 32'd0);

        // Ack timeout
        ack_en = 1'b0;
        do_reset();
        kick();
        @(negedge clk);
        check("to load entry", 32'(ir_ena), 32'd1);
        for (int i = 0; i < int'(AT); i++) begin
            @(negedge clk);
            check("to err early", 32'(err), 32'd0);
        end
        @(negedge clk);
`ifdef INSTR_SEQ_ACK_TIMEOUT_EN
        check("to err",    32'(err),    32'd1);
        check("to ir_ena", 32'(ir_ena), 32'd0);
        check("to busy",   32'(busy),   32'd0);
        repeat (3) @(negedge clk);
        check("to err holds", 32'(err), 32'd1);
`else
        check("to no err", 32'(err),    32'd0);
        check("to waits",  32'(ir_ena), 32'd1);
        repeat (10) @(negedge clk);
        check("to still waits", 32'(ir_ena), 32'd1);
        check("to err stays 0", 32'(err), 32'd0);
`endif
        ack_en = 1'b1;

        // Random programs with random fetch stalls
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            do_reset();
            kick();
            for (int k = 0; k < 12 && !m_halt; k++) run_instr("rand", 1'b1, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
